// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring-counter receive path.
package ring_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    TRACK,
    LOCKED
  } ring_state_t;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_LOCK_N = 2;

  // Position that should follow cur when the source advances by one step.
  function automatic int unsigned next_idx(input int unsigned cur, input int unsigned width);
    return (cur + 1 >= width) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/ring_decoder_if.sv
// Word input and status outputs of the ring decoder, grouped as one bus.
interface ring_decoder_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8,
  parameter int ROT_W = 8
);
  localparam int IW = $clog2(WIDTH);

  logic [WIDTH-1:0] d;
  logic             dv;
  logic [IW-1:0]    idx;
  logic             idx_v;
  logic             legal;
  logic             locked;
  logic             step_err;
  logic [ERR_W-1:0] err_cnt;
  logic [ROT_W-1:0] rot_cnt;

  modport master (
    output d, dv,
    input  idx, idx_v, legal, locked, step_err, err_cnt, rot_cnt
  );

  modport slave (
    input  d, dv,
    output idx, idx_v, legal, locked, step_err, err_cnt, rot_cnt
  );
endinterface

// File: rtl/ring_onehot_dec.sv
// Combinational one-hot to position decoder; the MSB is position 0.
module ring_onehot_dec #(
  parameter int WIDTH = 4,
  parameter int IW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] d,
  output logic [IW-1:0]    idx,
  output logic             legal
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] ones;
  logic          found;

  // Priority pick of the lowest position, alongside a popcount for legality.
  always_comb begin
    ones  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (d[WIDTH-1-i]) begin
        ones = ones + CW'(1);
        if (!found) begin
          idx   = IW'(i);
          found = 1'b1;
        end
      end
    end
    legal = (ones == CW'(1));
  end

endmodule

// File: rtl/ring_decoder.sv
// Ring-counter receiver: decodes position, locks onto a rotating sequence,
// counts rotations and flags out-of-sequence or illegal words.
module ring_decoder
  import ring_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LOCK_N = DEF_LOCK_N,
  parameter int ERR_W  = 8,
  parameter int ROT_W  = 8
) (
  input logic     c,
  input logic     r,
  ring_decoder_if.slave bus
);
  localparam int IW = $clog2(WIDTH);
  localparam int RW = $clog2(LOCK_N + 1);

  ring_state_t   state;
  logic [RW-1:0] run;
  logic [IW-1:0] prev;

  logic [IW-1:0] dec_idx;
  logic          dec_legal;
  logic          in_step;
  logic          wrap;

  ring_onehot_dec #(.WIDTH(WIDTH), .IW(IW)) u_dec (
    .d     (bus.d),
    .idx   (dec_idx),
    .legal (dec_legal)
  );

  assign in_step = dec_legal && (dec_idx == IW'(next_idx(32'(prev), WIDTH)));
  assign wrap    = (prev == IW'(WIDTH - 1));

  // Single state machine; every output is registered here and only moves on dv.
  always_ff @(posedge c) begin
    if (r) begin
      state        <= SEARCH;
      run          <= '0;
      prev         <= '0;
      bus.idx      <= '0;
      bus.idx_v    <= 1'b0;
      bus.legal    <= 1'b0;
      bus.locked   <= 1'b0;
      bus.step_err <= 1'b0;
      bus.err_cnt  <= '0;
      bus.rot_cnt  <= '0;
    end else begin
      bus.idx_v    <= 1'b0;
      bus.step_err <= 1'b0;
      if (bus.dv) begin
        bus.legal <= dec_legal;
        bus.idx_v <= dec_legal;
        if (dec_legal) begin
          bus.idx <= dec_idx;
          prev    <= dec_idx;
        end
        unique case (state)
          SEARCH: begin
            if (dec_legal) begin
              state <= TRACK;
              run   <= '0;
            end
          end
          TRACK: begin
            if (!dec_legal) begin
              state <= SEARCH;
            end else if (in_step) begin
              run <= run + RW'(1);
              if (int'(run) + 1 == LOCK_N) begin
                state      <= LOCKED;
                bus.locked <= 1'b1;
              end
            end else begin
              run <= '0;
            end
          end
          LOCKED: begin
            if (in_step) begin
              if (wrap) bus.rot_cnt <= bus.rot_cnt + ROT_W'(1);
            end else begin
              state        <= SEARCH;
              bus.locked   <= 1'b0;
              bus.step_err <= 1'b1;
              if (bus.err_cnt != '1) bus.err_cnt <= bus.err_cnt + ERR_W'(1);
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ring_decoder.sv
// Directed-vector bench for ring_decoder with a queue-based scoreboard.
module tb_ring_decoder;

  typedef struct packed {
    logic [1:0] idx;
    logic       iv;
    logic       lg;
    logic       lk;
    logic       se;
    logic [1:0] err;
    logic [7:0] rot;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sbq[$];

  ring_decoder_if #(.WIDTH(4), .ERR_W(2), .ROT_W(8)) bus ();

  ring_decoder #(.WIDTH(4), .LOCK_N(2), .ERR_W(2), .ROT_W(8)) dut (
    .c   (clk),
    .r   (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic rr, input logic dvv, input logic [3:0] dd,
                               input int ei, input int iv, input int lg, input int lk,
                               input int se, input int er, input int ro);
    exp_t e;
    @(negedge clk);
    rst    = rr;
    bus.dv = dvv;
    bus.d  = dd;
    e.idx  = 2'(ei);
    e.iv   = 1'(iv);
    e.lg   = 1'(lg);
    e.lk   = 1'(lk);
    e.se   = 1'(se);
    e.err  = 2'(er);
    e.rot  = 8'(ro);
    sbq.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    exp_t a;
    a = '{bus.idx, bus.idx_v, bus.legal, bus.locked, bus.step_err, bus.err_cnt, bus.rot_cnt};
    checks++;
    if (a !== e) begin
      failures++;
      $display("[TB] FAIL out#%0d got idx=%0d iv=%b lg=%b lk=%b se=%b err=%0d rot=%0d want idx=%0d iv=%b lg=%b lk=%b se=%b err=%0d rot=%0d",
               checks, a.idx, a.iv, a.lg, a.lk, a.se, a.err, a.rot,
               e.idx, e.iv, e.lg, e.lk, e.se, e.err, e.rot);
    end
  endtask

  // Monitor: one registered result per driven cycle, sampled after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (sbq.size() > 0) checkOutput(sbq.pop_front());
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.dv   = 1'b0;
    bus.d    = 4'b0000;

    applyStimulus(1, 0, 4'b0000, 0,0,0,0,0,0,0);
    applyStimulus(1, 1, 4'b1000, 0,0,0,0,0,0,0);

    // clean rotation, lock on third word, rotation counted on wrap in LOCKED
    applyStimulus(0, 1, 4'b1000, 0,1,1,0,0,0,0);
    applyStimulus(0, 1, 4'b0100, 1,1,1,0,0,0,0);
    applyStimulus(0, 1, 4'b0010, 2,1,1,1,0,0,0);
    applyStimulus(0, 1, 4'b0001, 3,1,1,1,0,0,0);
    applyStimulus(0, 1, 4'b1000, 0,1,1,1,0,0,1);
    applyStimulus(0, 1, 4'b0100, 1,1,1,1,0,0,1);
    applyStimulus(0, 1, 4'b0010, 2,1,1,1,0,0,1);
    applyStimulus(0, 1, 4'b0001, 3,1,1,1,0,0,1);
    applyStimulus(0, 1, 4'b1000, 0,1,1,1,0,0,2);

    // sequence fault, then re-lock over three words
    applyStimulus(0, 1, 4'b0010, 2,1,1,0,1,1,2);
    applyStimulus(0, 1, 4'b0001, 3,1,1,0,0,1,2);
    applyStimulus(0, 1, 4'b1000, 0,1,1,0,0,1,2);
    applyStimulus(0, 1, 4'b0100, 1,1,1,1,0,1,2);

    // stall with garbage on d
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 4'b1111, 1,0,1,1,0,1,2);
    applyStimulus(0, 1, 4'b0010, 2,1,1,1,0,1,2);
    applyStimulus(0, 1, 4'b0001, 3,1,1,1,0,1,2);
    applyStimulus(0, 1, 4'b1000, 0,1,1,1,0,1,3);

    // illegal words: zero faults, multi-hot in SEARCH is silent
    applyStimulus(0, 1, 4'b0000, 0,0,0,0,1,2,3);
    applyStimulus(0, 1, 4'b1100, 0,0,0,0,0,2,3);
    applyStimulus(0, 1, 4'b0100, 1,1,1,0,0,2,3);
    applyStimulus(0, 1, 4'b0010, 2,1,1,0,0,2,3);
    applyStimulus(0, 1, 4'b0001, 3,1,1,1,0,2,3);

    // reset beats a legal word while locked
    applyStimulus(1, 1, 4'b1000, 0,0,0,0,0,0,0);

    // saturation of the 2-bit error counter
    applyStimulus(0, 1, 4'b1000, 0,1,1,0,0,0,0);
    applyStimulus(0, 1, 4'b0100, 1,1,1,0,0,0,0);
    applyStimulus(0, 1, 4'b0010, 2,1,1,1,0,0,0);
    applyStimulus(0, 1, 4'b1000, 0,1,1,0,1,1,0);
    applyStimulus(0, 1, 4'b0100, 1,1,1,0,0,1,0);
    applyStimulus(0, 1, 4'b0010, 2,1,1,0,0,1,0);
    applyStimulus(0, 1, 4'b0001, 3,1,1,1,0,1,0);
    applyStimulus(0, 1, 4'b0100, 1,1,1,0,1,2,0);
    applyStimulus(0, 1, 4'b0010, 2,1,1,0,0,2,0);
    applyStimulus(0, 1, 4'b0001, 3,1,1,0,0,2,0);
    applyStimulus(0, 1, 4'b1000, 0,1,1,1,0,2,0);
    applyStimulus(0, 1, 4'b0001, 3,1,1,0,1,3,0);
    applyStimulus(0, 1, 4'b1000, 0,1,1,0,0,3,0);
    applyStimulus(0, 1, 4'b0100, 1,1,1,0,0,3,0);
    applyStimulus(0, 1, 4'b0010, 2,1,1,1,0,3,0);
    applyStimulus(0, 1, 4'b0010, 2,1,1,0,1,3,0);
    applyStimulus(0, 1, 4'b0001, 3,1,1,0,0,3,0);
    applyStimulus(0, 1, 4'b1000, 0,1,1,0,0,3,0);
    applyStimulus(0, 1, 4'b0100, 1,1,1,1,0,3,0);
    applyStimulus(0, 1, 4'b1111, 1,0,0,0,1,3,0);
    applyStimulus(0, 0, 4'b0000, 1,0,0,0,0,3,0);

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain got pending=%0d want pending=0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ring_decoder.md
# ring_decoder

Receive-side companion to the 4-bit ring counter: samples a ring-counter word each valid cycle, converts the one-hot code to a binary position index, and checks that successive words advance by exactly one position. Once locked onto a correctly rotating sequence, it counts full rotations and flags, counts and recovers from illegal or out-of-sequence words. It sits downstream of any ring-counter source, either as a sequencer-state decoder or as a health monitor.

## Interface
- WIDTH, 4: ring length in bits; must be ≥ 2.
- LOCK_N, 2: consecutive correct steps required to enter LOCKED; must be ≥ 1.
- ERR_W, 8: width of the saturating error counter.
- ROT_W, 8: width of the wrapping rotation counter.

- c  in  1  clock; all logic is on the rising edge.
- r  in  1  reset; synchronous, active-high.
- d  in  WIDTH  ring word sampled from the source.
- dv  in  1  d is valid this cycle.
- idx  out  $clog2(WIDTH)  binary position of the last legal word.
- idx_v  out  1  idx was updated from a legal word on the previous valid cycle.
- legal  out  1  last sampled valid word was exactly one-hot.
- locked  out  1  FSM is in LOCKED.
- step_err  out  1  one-cycle pulse on a sequence or legality fault while LOCKED.
- err_cnt  out  ERR_W  saturating count of step_err pulses.
- rot_cnt  out  ROT_W  count of completed rotations while LOCKED; wraps.

## Operation
- Position map: d[WIDTH-1] set → index 0 (1000 is the source reset word); d[0] set → index WIDTH-1. Source shifts right, so the expected next index is (idx+1) mod WIDTH.
- Legal word: exactly one bit set. All-zero and multi-hot words are illegal.
- dv low: nothing changes. State, run count, outputs and counters hold, except that idx_v and step_err drop to 0.
- FSM states are SEARCH, TRACK and LOCKED; reset enters SEARCH. All transitions below occur only on cycles with dv=1.
  - SEARCH, legal word: go to TRACK, store prev=index, set run=0.
  - SEARCH, illegal word: stay in SEARCH.
  - TRACK, legal word and index==prev+1 mod WIDTH: increment run. If run+1==LOCK_N, go to LOCKED.
  - TRACK, legal word and any other index: stay in TRACK, set run=0, set prev=index.
  - TRACK, illegal word: go to SEARCH.
  - LOCKED, legal word and expected index: stay in LOCKED. If the step is a wrap (prev=WIDTH-1 → 0), increment rot_cnt.
  - LOCKED, unexpected index or illegal word: pulse step_err, increment err_cnt (saturating at all-ones), go to SEARCH.
- Counter behaviour:
  - err_cnt holds at 2^ERR_W−1 and never wraps.
  - rot_cnt wraps modulo 2^ROT_W and increments only in LOCKED.
- Output updates:
  - idx updates only on legal words.
  - legal updates on every dv=1 cycle.
  - On an illegal word, idx keeps its prior value and idx_v=0.
- The step taken into LOCKED does not count as a rotation, even if it wraps.

## Timing
- All outputs are registered. A word sampled on edge k appears on idx, idx_v, legal, locked and step_err after edge k; latency is 1 cycle.
- Reset values: idx=0, idx_v=0, legal=0, locked=0, step_err=0, err_cnt=0, rot_cnt=0, FSM state SEARCH, run=0, prev=0.
- Reset has priority over dv on the same edge, and r asserted mid-rotation discards all tracking state.
- Lock latency: a clean sequence reaches locked=1 after LOCK_N+1 valid words, measured from SEARCH.
- A fault while LOCKED gives step_err=1 and locked=0 together in the cycle after the bad word. Re-lock needs LOCK_N+1 further valid words.
- Throughput: one word per clock; dv may toggle arbitrarily.

## Structure
- Shared package ring_pkg holds:
  - the state enum type (SEARCH, TRACK, LOCKED);
  - default constants for WIDTH and LOCK_N;
  - a function returning the expected next index mod WIDTH.
- Sub-module ring_onehot_dec is purely combinational. It maps d to its index plus a legal flag, using a popcount==1 check and a priority index.
- The top level holds the FSM, run/prev registers, counters and output registers.

## Test plan
- Reset then clean source (1000,0100,0010,0001,1000…) with dv=1 → locked=1 on the 3rd output cycle; idx follows 0,1,2,3,0; rot_cnt=1 after the first 0001→1000 step taken in LOCKED.
- Locked, inject 0010 where 0100 is expected → step_err=1 for one cycle, err_cnt=1, locked=0, idx=2; re-lock after 3 more clean words.
- Locked, inject 0000 then 1100 → each word gives legal=0 and idx_v=0 with idx held; only the first raises step_err; err_cnt=1; FSM is in SEARCH.
- dv low for 5 cycles mid-sequence, then resume at the expected word → no error, locked stays 1, idx and rot_cnt hold during the stall.
- ERR_W=2, force 5 faults with re-lock between them → err_cnt reads 1,2,3,3,3.
- Assert r while LOCKED with dv=1 and a legal word → all outputs return to 0 on the next edge; the word is ignored.
